// File: rtl/tff_bank.sv
// tff_bank: a bank of WIDTH gated toggle flip-flops sharing one control path.
// Each bit can hold, toggle under a per-bit gate, or load from d. The whole
// bank can also act as a synchronous T-chain up/down counter that reports
// terminal count. Every output is registered with one cycle of latency.
module tff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             gate,
    input  logic [WIDTH-1:0]             t,
    input  logic [WIDTH-1:0]             d,
    input  logic                         up,
    output logic [WIDTH-1:0]             q,
    output logic                         tc,
    output logic                         changed,
    output logic [$clog2(WIDTH+1)-1:0]   flips
);

    localparam int FW = $clog2(WIDTH+1);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             changed_q, changed_d;
    logic [FW-1:0]    flips_q, flips_d;

    // ones_chain[i]: bits [i-1:0] are all 1. zeros_chain[i]: bits [i-1:0] are all 0.
    // Index WIDTH covers the whole bank and marks the wrap point.
    logic [WIDTH:0]   ones_chain;
    logic [WIDTH:0]   zeros_chain;
    logic [WIDTH-1:0] count_val;
    logic [WIDTH-1:0] diff;

    assign ones_chain[0]  = 1'b1;
    assign zeros_chain[0] = 1'b1;

    // T-chain: a bit toggles when every lower bit is at the carry/borrow value.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
            assign ones_chain[gi+1]  = ones_chain[gi] & q_q[gi];
            assign zeros_chain[gi+1] = zeros_chain[gi] & ~q_q[gi];
            assign count_val[gi]     = q_q[gi] ^ (up ? ones_chain[gi] : zeros_chain[gi]);
        end
    endgenerate

    // Select the next bank value and the terminal-count flag from the mode.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (enable) begin
            case (mode)
                MODE_HOLD:   q_d = q_q;
                MODE_TOGGLE: q_d = q_q ^ (t & gate);
                MODE_LOAD:   q_d = (q_q & ~gate) | (d & gate);
                MODE_COUNT: begin
                    q_d  = count_val;
                    tc_d = up ? ones_chain[WIDTH] : zeros_chain[WIDTH];
                end
                default:     q_d = q_q;
            endcase
        end
    end

    // Change detection: any-bit-changed flag and a popcount of the changed bits.
    always_comb begin
        diff      = q_q ^ q_d;
        changed_d = |diff;
        flips_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flips_d = flips_d + FW'(diff[i]);
        end
    end

    // State and status registers; reset has priority over enable and mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q       <= RESET_VAL;
            tc_q      <= 1'b0;
            changed_q <= 1'b0;
            flips_q   <= '0;
        end else begin
            q_q       <= q_d;
            tc_q      <= tc_d;
            changed_q <= changed_d;
            flips_q   <= flips_d;
        end
    end

    assign q       = q_q;
    assign tc      = tc_q;
    assign changed = changed_q;
    assign flips   = flips_q;

endmodule

// File: doc/tff_bank.md
# tff_bank

Parametrised bank of WIDTH gated toggle flip-flops with a shared synchronous control path. This is the clocked, multi-bit successor of the single gated T latch. Each bit can hold, toggle under a per-bit gate, or load from d. The whole bank can also run as a T-chain up/down counter with terminal-count detection. It sits in the sequential library as the generic toggle/count register used by counters and divider blocks.

## Interface
- WIDTH, 8, number of flip-flops in the bank (≥ 2)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk
- enable  input  1  global enable; 0 freezes the bank
- mode  input  2  00 hold, 01 toggle, 10 load, 11 count
- gate  input  WIDTH  per-bit gate for toggle and load modes
- t  input  WIDTH  per-bit toggle request (toggle mode)
- d  input  WIDTH  per-bit load data (load mode)
- up  input  1  count direction in mode 11: 1 up, 0 down
- q  output  WIDTH  registered bank state
- tc  output  1  registered terminal-count pulse: count mode wrapped on this update
- changed  output  1  registered: q differs from its previous value
- flips  output  $clog2(WIDTH+1)  registered: number of bits of q that changed on this update

## Operation
- Priority on each rising clk: rst_n=0, then enable=0, then mode.
- rst_n=0: q=RESET_VAL, tc=0, changed=0, flips=0. Reset applies regardless of enable or mode, and also mid-count.
- enable=0: q holds. tc, changed and flips are forced to 0.
- mode 00 (hold): q holds. tc=0, changed=0, flips=0.
- mode 01 (toggle): q_next = q ^ (t & gate). Bits with gate=0 or t=0 hold.
- mode 10 (load): q_next = (q & ~gate) | (d & gate). A load with gate=0 on a bit leaves that bit unchanged.
- mode 11 (count): gate, t and d are ignored. The bank is a synchronous T-chain.
  - up=1: bit i toggles when bits [i-1:0] are all 1. Bit 0 always toggles. Result is q+1 mod 2^WIDTH.
  - up=0: bit i toggles when bits [i-1:0] are all 0. Bit 0 always toggles. Result is q−1 mod 2^WIDTH.
  - tc_next = 1 when up=1 and q is all ones, or when up=0 and q is all zeros. Otherwise tc_next = 0.
- In all non-reset, enabled modes:
  - changed_next = |(q ^ q_next)
  - flips_next = popcount(q ^ q_next)
  - Both are unsigned values, and flips never exceeds WIDTH.
- Direction change in count mode takes effect on the same edge; no state is carried between modes.
- Mode change takes effect on the edge where the new mode is sampled. Count mode has no hidden state beyond q.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency is 1 cycle. Inputs sampled at edge k produce q, tc, changed and flips visible after edge k, all aligned.
- tc is a single-cycle pulse per wrap. Continuous counting at WIDTH=8 gives one tc every 256 enabled count cycles.
- The state after reset release is RESET_VAL. The first update happens on the first edge with rst_n=1 and enable=1.
- Holding enable=0 mid-count freezes q. Counting resumes from the frozen value with no lost or extra step.
- rst_n=0 for one edge is sufficient.

## Test plan
- Reset with WIDTH=8, RESET_VAL=8'hA5, then rst_n=1, enable=0 for 3 cycles → q=8'hA5, tc=0, changed=0, flips=0 throughout.
- Toggle with q=8'h00, mode=01, t=8'hFF, gate=8'h0F for one edge → q=8'h0F, changed=1, flips=4. Repeat the same edge → q=8'h00, flips=4.
- Load with q=8'h0F, mode=10, d=8'hF0, gate=8'hCC → q=8'hC3, flips=4. Then gate=8'h00 → q stays 8'hC3, changed=0, flips=0.
- Count up from q=8'hFE, mode=11, up=1 for 3 edges → q sequence FF, 00, 01. tc=1 only on the update to 00, with flips=8 on that update. Then up=0 for 2 edges → 00, FF; tc=1 on the update to FF.
- Enable gap: count up from 8'h10, drop enable for 4 cycles mid-run, then re-enable → q continues 8'h12 to 8'h13 with no skip. tc, changed and flips are 0 while disabled.
- Reset mid-count: q=8'h7F counting up, assert rst_n=0 for one edge with enable=1 → q=RESET_VAL next cycle and tc=0. Counting restarts from RESET_VAL on the next enabled edge.
